// File: rtl/yuv_to_rgb_conv.sv
// Y'UV444 to RGB colour-space converter: 2-entry input skid buffer feeding a
// 4-stage (offset, multiply, sum/shift, clamp) pipeline with per-packet mode.
module yuv_to_rgb_conv #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1,
    parameter int CHAIN_ID   = 0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [1:0]              mode,
    input  logic [7:0]              alpha,
    input  logic                    src_t_valid,
    output logic                    src_t_ready,
    input  logic [DATA_WIDTH-1:0]   src_t_data,
    input  logic [DATA_WIDTH/8-1:0] src_t_keep,
    input  logic                    src_t_last,
    input  logic [USER_WIDTH-1:0]   src_t_user,
    output logic                    dst_t_valid,
    input  logic                    dst_t_ready,
    output logic [DATA_WIDTH-1:0]   dst_t_data,
    output logic [DATA_WIDTH/8-1:0] dst_t_keep,
    output logic [DATA_WIDTH/8-1:0] dst_t_strb,
    output logic                    dst_t_last,
    output logic [USER_WIDTH-1:0]   dst_t_user,
    output logic [DEST_WIDTH-1:0]   dst_t_dest,
    output logic                    dst_t_id,
    output logic [31:0]             pkt_count
);

    localparam int PIXELS = DATA_WIDTH / 32;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
        logic [1:0]            mode;
        logic [7:0]            alpha;
    } beat_t;

    typedef struct packed {
        logic signed [11:0] ky;
        logic signed [11:0] kr;
        logic signed [11:0] kgu;
        logic signed [11:0] kgv;
        logic signed [11:0] kbu;
    } coef_t;

    function automatic coef_t coef_sel(input logic [1:0] m);
        coef_t c;
        case (m)
            2'd1:    c = '{12'sd256, 12'sd359, 12'sd88,  12'sd183, 12'sd454};
            2'd2:    c = '{12'sd298, 12'sd459, 12'sd55,  12'sd136, 12'sd541};
            default: c = '{12'sd298, 12'sd409, 12'sd100, 12'sd208, 12'sd516};
        endcase
        return c;
    endfunction

    function automatic logic [7:0] sat8(input logic signed [11:0] x);
        if (x < 0)
            return 8'd0;
        else if (x > 12'sd255)
            return 8'd255;
        else
            return x[7:0];
    endfunction

    // Handshake / flow-control state
    logic [1:0] sk_count, sk_count_nxt;
    beat_t      sk [2];
    logic       wr_idx;
    logic       push, pop, push_sk;
    logic       first_q;
    logic [1:0] mode_q;
    logic [7:0] alpha_q;
    logic       s1_v, s2_v, s3_v;
    logic       s0_v;
    logic       ld1, ld2, ld3, ld4;

    beat_t in_beat, s0_beat, s1_beat, s2_beat, s3_beat;

    // Datapath
    logic signed [9:0]  c_nxt [PIXELS];
    logic signed [8:0]  d_nxt [PIXELS];
    logic signed [8:0]  e_nxt [PIXELS];
    logic signed [9:0]  s1_c  [PIXELS];
    logic signed [8:0]  s1_d  [PIXELS];
    logic signed [8:0]  s1_e  [PIXELS];
    logic signed [9:0]  yoff;
    coef_t              kc;
    logic signed [19:0] yc_nxt [PIXELS];
    logic signed [19:0] re_nxt [PIXELS];
    logic signed [19:0] gu_nxt [PIXELS];
    logic signed [19:0] gv_nxt [PIXELS];
    logic signed [19:0] bu_nxt [PIXELS];
    logic signed [19:0] s2_yc  [PIXELS];
    logic signed [19:0] s2_re  [PIXELS];
    logic signed [19:0] s2_gu  [PIXELS];
    logic signed [19:0] s2_gv  [PIXELS];
    logic signed [19:0] s2_bu  [PIXELS];
    logic signed [19:0] sum_r, sum_g, sum_b;
    logic signed [11:0] red_nxt [PIXELS];
    logic signed [11:0] grn_nxt [PIXELS];
    logic signed [11:0] blu_nxt [PIXELS];
    logic signed [11:0] s3_red  [PIXELS];
    logic signed [11:0] s3_grn  [PIXELS];
    logic signed [11:0] s3_blu  [PIXELS];
    logic [DATA_WIDTH-1:0] out_nxt;

    assign dst_t_keep = '1;
    assign dst_t_strb = '1;
    assign dst_t_id   = 1'b0;

    // Mode/alpha are frozen for the whole packet at the handshake of its first beat.
    always_comb begin
        in_beat.data  = src_t_data;
        in_beat.last  = src_t_last;
        in_beat.user  = src_t_user;
        in_beat.mode  = first_q ? mode  : mode_q;
        in_beat.alpha = first_q ? alpha : alpha_q;
    end

    always_comb begin
        push    = src_t_valid && src_t_ready;
        ld4     = !dst_t_valid || dst_t_ready;
        ld3     = !s3_v || ld4;
        ld2     = !s2_v || ld3;
        ld1     = !s1_v || ld2;
        s0_v    = (sk_count != 2'd0) || push;
        s0_beat = (sk_count != 2'd0) ? sk[0] : in_beat;
        pop     = ld1 && (sk_count != 2'd0);
        push_sk = push && !(ld1 && (sk_count == 2'd0));
        wr_idx  = sk_count[0] & ~pop;
        sk_count_nxt = sk_count + 2'(push_sk) - 2'(pop);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sk_count    <= 2'd0;
            src_t_ready <= 1'b0;
            first_q     <= 1'b1;
            mode_q      <= 2'd0;
            alpha_q     <= 8'd0;
            s1_v        <= 1'b0;
            s2_v        <= 1'b0;
            s3_v        <= 1'b0;
            dst_t_valid <= 1'b0;
            dst_t_last  <= 1'b0;
            pkt_count   <= 32'd0;
        end else begin
            sk_count    <= sk_count_nxt;
            src_t_ready <= (sk_count_nxt != 2'd2);
            if (push) begin
                first_q <= src_t_last;
                if (first_q) begin
                    mode_q  <= mode;
                    alpha_q <= alpha;
                end
            end
            if (ld1) s1_v <= s0_v;
            if (ld2) s2_v <= s1_v;
            if (ld3) s3_v <= s2_v;
            if (ld4) begin
                dst_t_valid <= s3_v;
                dst_t_last  <= s3_v && s3_beat.last;
            end
            if (dst_t_valid && dst_t_ready && dst_t_last)
                pkt_count <= pkt_count + 32'd1;
        end
    end

    always_comb begin
        yoff = (s0_beat.mode == 2'd1) ? 10'sd0 : 10'sd16;
        for (int k = 0; k < PIXELS; k++) begin
            c_nxt[k] = $signed({2'b00, s0_beat.data[32*k+16 +: 8]}) - yoff;
            d_nxt[k] = $signed({1'b0,  s0_beat.data[32*k+8  +: 8]}) - 9'sd128;
            e_nxt[k] = $signed({1'b0,  s0_beat.data[32*k    +: 8]}) - 9'sd128;
        end
    end

    always_comb begin
        kc = coef_sel(s1_beat.mode);
        for (int k = 0; k < PIXELS; k++) begin
            yc_nxt[k] = 20'(s1_c[k]) * 20'(kc.ky);
            re_nxt[k] = 20'(s1_e[k]) * 20'(kc.kr);
            gu_nxt[k] = 20'(s1_d[k]) * 20'(kc.kgu);
            gv_nxt[k] = 20'(s1_e[k]) * 20'(kc.kgv);
            bu_nxt[k] = 20'(s1_d[k]) * 20'(kc.kbu);
        end
    end

    always_comb begin
        sum_r = '0;
        sum_g = '0;
        sum_b = '0;
        for (int k = 0; k < PIXELS; k++) begin
            sum_r      = s2_yc[k] + s2_re[k] + 20'sd128;
            sum_g      = s2_yc[k] - s2_gu[k] - s2_gv[k] + 20'sd128;
            sum_b      = s2_yc[k] + s2_bu[k] + 20'sd128;
            red_nxt[k] = 12'(sum_r >>> 8);
            grn_nxt[k] = 12'(sum_g >>> 8);
            blu_nxt[k] = 12'(sum_b >>> 8);
        end
    end

    // Bypass mode forwards the original lane word, byte 3 included.
    always_comb begin
        out_nxt = s3_beat.data;
        if (s3_beat.mode != 2'd3) begin
            for (int k = 0; k < PIXELS; k++)
                out_nxt[32*k +: 32] = {s3_beat.alpha, sat8(s3_red[k]), sat8(s3_grn[k]), sat8(s3_blu[k])};
        end
    end

    // NOTE: payload registers carry no reset; only valid flags, counters and
    // sideband with a defined reset value live in the reset block above.
    always_ff @(posedge aclk) begin
        if (pop)
            sk[0] <= sk[1];
        if (push_sk)
            sk[wr_idx] <= in_beat;
        if (ld1) begin
            s1_beat <= s0_beat;
            s1_c    <= c_nxt;
            s1_d    <= d_nxt;
            s1_e    <= e_nxt;
        end
        if (ld2) begin
            s2_beat <= s1_beat;
            s2_yc   <= yc_nxt;
            s2_re   <= re_nxt;
            s2_gu   <= gu_nxt;
            s2_gv   <= gv_nxt;
            s2_bu   <= bu_nxt;
        end
        if (ld3) begin
            s3_beat <= s2_beat;
            s3_red  <= red_nxt;
            s3_grn  <= grn_nxt;
            s3_blu  <= blu_nxt;
        end
        if (ld4) begin
            dst_t_data <= out_nxt;
            dst_t_user <= s3_beat.user >> 1;
            dst_t_dest <= s3_beat.user[0] ? DEST_WIDTH'(CHAIN_ID) : '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn && src_t_valid && src_t_ready)
            assert (&src_t_keep)
            else $error("yuv_to_rgb_conv: partial src beat treated as full");
    end

endmodule

// File: tb/tb_yuv_to_rgb_conv.sv
// Scoreboard bench for yuv_to_rgb_conv: a driver pushes model results into a
// queue at each src handshake; a monitor pops and compares at each dst handshake.
module tb_yuv_to_rgb_conv;

    localparam int DW  = 64;
    localparam int UW  = 2;
    localparam int DSW = 3;
    localparam int CID = 5;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [7:0]    alpha = 8'd0;
    logic          src_t_valid = 1'b0;
    logic          src_t_ready;
    logic [DW-1:0] src_t_data = '0;
    logic [7:0]    src_t_keep = 8'hFF;
    logic          src_t_last = 1'b0;
    logic [UW-1:0] src_t_user = '0;
    logic          dst_t_valid;
    logic          dst_t_ready = 1'b0;
    logic [DW-1:0] dst_t_data;
    logic [7:0]    dst_t_keep;
    logic [7:0]    dst_t_strb;
    logic          dst_t_last;
    logic [UW-1:0] dst_t_user;
    logic [DSW-1:0] dst_t_dest;
    logic          dst_t_id;
    logic [31:0]   pkt_count;

    yuv_to_rgb_conv #(
        .DATA_WIDTH(DW), .USER_WIDTH(UW), .DEST_WIDTH(DSW), .CHAIN_ID(CID)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .mode(mode), .alpha(alpha),
        .src_t_valid(src_t_valid), .src_t_ready(src_t_ready), .src_t_data(src_t_data),
        .src_t_keep(src_t_keep), .src_t_last(src_t_last), .src_t_user(src_t_user),
        .dst_t_valid(dst_t_valid), .dst_t_ready(dst_t_ready), .dst_t_data(dst_t_data),
        .dst_t_keep(dst_t_keep), .dst_t_strb(dst_t_strb), .dst_t_last(dst_t_last),
        .dst_t_user(dst_t_user), .dst_t_dest(dst_t_dest), .dst_t_id(dst_t_id),
        .pkt_count(pkt_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DW-1:0]  data;
        logic           last;
        logic [UW-1:0]  user;
        logic [DSW-1:0] dest;
        int             acc_cyc;
        bit             lat_chk;
    } exp_t;

    exp_t   q[$];
    exp_t   mon_e;
    int     n_vec = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     ready_pct = 100;
    int     idle_pct = 0;
    int     exp_pkts = 0;
    bit     first_beat = 1'b1;
    logic [1:0] pkt_mode = 2'd0;
    logic [7:0] pkt_alpha = 8'd0;
    bit     held_v = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic [31:0] pkt_before;

    always @(posedge aclk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] clamp8(input int v);
        logic [31:0] w;
        w = v;
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return w[7:0];
    endfunction

    // Reference conversion of one pixel lane, straight from the colour equations.
    function automatic logic [31:0] ref_lane(input logic [31:0] px, input logic [1:0] m, input logic [7:0] a);
        int c, d, e, ky, kr, kgu, kgv, kbu;
        if (m == 2'd3) return px;
        c = int'(px[23:16]) - ((m == 2'd1) ? 0 : 16);
        d = int'(px[15:8]) - 128;
        e = int'(px[7:0]) - 128;
        case (m)
            2'd0:    begin ky = 298; kr = 409; kgu = 100; kgv = 208; kbu = 516; end
            2'd1:    begin ky = 256; kr = 359; kgu = 88;  kgv = 183; kbu = 454; end
            default: begin ky = 298; kr = 459; kgu = 55;  kgv = 136; kbu = 541; end
        endcase
        return {a,
                clamp8((ky*c + kr*e + 128) >>> 8),
                clamp8((ky*c - kgu*d - kgv*e + 128) >>> 8),
                clamp8((ky*c + kbu*d + 128) >>> 8)};
    endfunction

    function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] data, input logic [1:0] m, input logic [7:0] a);
        logic [DW-1:0] r;
        for (int k = 0; k < DW/32; k++)
            r[32*k +: 32] = ref_lane(data[32*k +: 32], m, a);
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input logic [DW-1:0] data, input logic last, input logic [UW-1:0] user,
                        input bit use_exp = 1'b0, input logic [DW-1:0] exp_data = '0);
        exp_t e;
        bit   acc;
        int   waitc;
        while ($urandom_range(99) < idle_pct) begin
            src_t_valid = 1'b0;
            @(negedge aclk);
        end
        src_t_valid = 1'b1;
        src_t_data  = data;
        src_t_last  = last;
        src_t_user  = user;
        acc   = 1'b0;
        waitc = 0;
        while (!acc && waitc < 1000) begin
            acc = src_t_ready;
            if (acc) begin
                if (first_beat) begin
                    pkt_mode  = mode;
                    pkt_alpha = alpha;
                end
                first_beat = last;
                e.data    = use_exp ? exp_data : ref_beat(data, pkt_mode, pkt_alpha);
                e.last    = last;
                e.user    = user >> 1;
                e.dest    = user[0] ? DSW'(CID) : '0;
                e.acc_cyc = cyc;
                e.lat_chk = (ready_pct == 100);
                if (last) exp_pkts++;
                q.push_back(e);
            end
            @(negedge aclk);
            waitc++;
        end
        src_t_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_bad++;
            $display("FAIL src_accept_timeout: beat %h not accepted within %0d cycles", data, waitc);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        repeat (2) @(negedge aclk);
    endtask

    always @(negedge aclk) begin
        dst_t_ready = ($urandom_range(99) < ready_pct);
        if (!aresetn) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", 64'(dst_t_valid), 64'd1);
                check("hold_data", dst_t_data, held_data);
            end
            if (dst_t_valid && dst_t_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_beat: got data %h with nothing outstanding", dst_t_data);
                end else begin
                    mon_e = q.pop_front();
                    check("data", dst_t_data, mon_e.data);
                    check("last", 64'(dst_t_last), 64'(mon_e.last));
                    check("user", 64'(dst_t_user), 64'(mon_e.user));
                    check("dest", 64'(dst_t_dest), 64'(mon_e.dest));
                    check("keep_strb_id", {47'd0, dst_t_id, dst_t_strb, dst_t_keep}, {47'd0, 1'b0, 8'hFF, 8'hFF});
                    if (mon_e.lat_chk)
                        check("latency", 64'(cyc - mon_e.acc_cyc), 64'd4);
                end
            end
            held_v    = dst_t_valid && !dst_t_ready;
            held_data = dst_t_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_dst_valid", 64'(dst_t_valid), 64'd0);
        check("rst_dst_last", 64'(dst_t_last), 64'd0);
        check("rst_src_ready", 64'(src_t_ready), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1 check("release_src_ready", 64'(src_t_ready), 64'd1);
        @(negedge aclk);

        // Known colours, routing and bypass with dst always ready.
        ready_pct = 100;
        idle_pct  = 0;
        alpha = 8'hA5;
        mode  = 2'd0;
        send({32'h00108080, 32'h00EB8080}, 1'b0, 2'b11, 1'b1, {32'hA5000000, 32'hA5FFFFFF});
        send({32'h00108080, 32'h77515AF0}, 1'b1, 2'b10, 1'b1, {32'hA5000000, 32'hA5FF0000});
        mode = 2'd1;
        send({32'h00008080, 32'h00008080}, 1'b1, 2'b00, 1'b1, {32'hA5000000, 32'hA5000000});
        mode = 2'd3;
        send({32'hDEADBEEF, 32'h11223344}, 1'b1, 2'b01, 1'b1, {32'hDEADBEEF, 32'h11223344});
        drain();
        check("pkt_count_directed", 64'(pkt_count), 64'd3);

        // Mode/alpha change mid-packet only affects the following packet.
        mode  = 2'd0;
        alpha = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                mode  = 2'd2;
                alpha = 8'hC3;
            end
            send({$urandom, $urandom}, i == 4, 2'b00);
        end
        for (int i = 0; i < 2; i++)
            send({$urandom, $urandom}, i == 1, 2'b00);
        drain();

        // Reset with three beats stalled in the pipeline.
        ready_pct = 0;
        mode = 2'd0;
        for (int i = 0; i < 3; i++)
            send({$urandom, $urandom}, 1'b0, 2'b00);
        repeat (4) @(negedge aclk);
        check("stall_valid", 64'(dst_t_valid), 64'd1);
        #2 aresetn = 1'b0;
        #1;
        check("midrst_dst_valid", 64'(dst_t_valid), 64'd0);
        check("midrst_pkt_count", 64'(pkt_count), 64'd0);
        check("midrst_src_ready", 64'(src_t_ready), 64'd0);
        q.delete();
        first_beat = 1'b1;
        exp_pkts   = 0;
        @(negedge aclk);
        @(negedge aclk);
        ready_pct = 100;
        aresetn   = 1'b1;
        @(posedge aclk);
        #1 check("rerelease_src_ready", 64'(src_t_ready), 64'd1);
        @(negedge aclk);
        send({$urandom, $urandom}, 1'b1, 2'b01);
        drain();
        check("pkt_count_after_reset", 64'(pkt_count), 64'(exp_pkts));

        // 100-beat packet under random backpressure with mode/alpha wiggling.
        ready_pct  = 50;
        idle_pct   = 50;
        pkt_before = pkt_count;
        for (int i = 0; i < 100; i++) begin
            mode  = 2'($urandom);
            alpha = 8'($urandom);
            send({$urandom, $urandom}, i == 99, 2'($urandom));
        end
        drain();
        check("pkt_count_long", 64'(pkt_count - pkt_before), 64'd1);

        // Short random packets.
        for (int p = 0; p < 20; p++) begin
            int len;
            len = $urandom_range(6, 1);
            for (int i = 0; i < len; i++) begin
                mode  = 2'($urandom);
                alpha = 8'($urandom);
                send({$urandom, $urandom}, i == len - 1, 2'($urandom));
            end
        end
        drain();
        check("pkt_count_final", 64'(pkt_count), 64'(exp_pkts));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/yuv_to_rgb_conv.md
YUV_TO_RGB_CONV -- requirements
Module: yuv_to_rgb_conv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: stream data width in bits; a multiple of 32 and at least 32.
REQ-002 SHALL have parameter USER_WIDTH, default 1: width of t_user; must be at least 1.
REQ-003 SHALL have parameter DEST_WIDTH, default 1: width of t_dest.
REQ-004 SHALL have parameter CHAIN_ID, default 0: t_dest value for beats flagged for chaining.
REQ-005 SHALL derive localparam PIXELS = DATA_WIDTH/32: number of pixel lanes per beat.
REQ-006 SHALL have aclk  input  1  clock; the only clock domain.
REQ-007 SHALL have aresetn  input  1  reset; asynchronous and active-low.
REQ-008 SHALL have mode  input  2  conversion select: 0 BT.601 studio, 1 BT.601 full, 2 BT.709 studio, 3 bypass.
REQ-009 SHALL have alpha  input  8  value written to output byte 3 of every lane.
REQ-010 SHALL have src  nasti_stream_channel.slave  DATA_WIDTH  Y'UV444 input stream.
REQ-011 SHALL have dst  nasti_stream_channel.master  DATA_WIDTH  RGB output stream.
REQ-012 SHALL have pkt_count  output  32  number of t_last beats delivered on dst.

Function
REQ-013 Input lane k: byte 0 = V, byte 1 = U, byte 2 = Y, byte 3 ignored.
REQ-014 Output lane k: byte 0 = B, byte 1 = G, byte 2 = R, byte 3 = alpha (modes 0-2).
REQ-015 Pipeline: 4 stages (offset, multiply, sum/shift, clamp) plus a 2-entry input skid buffer.
REQ-016 Latency: beat accepted at cycle N appears on dst at cycle N+4 when dst.t_ready is held high.
REQ-017 Throughput: 1 beat/cycle sustained.
REQ-018 src.t_ready: registered; no combinational path from dst.t_ready.
REQ-019 Stages advance only when the next stage is empty or is itself advancing (bubble collapse).
REQ-020 No beat may be dropped, duplicated or reordered under any pattern of t_valid/t_ready.
REQ-021 dst.t_data, t_last, t_user, t_dest: stable while t_valid=1 and t_ready=0.
REQ-022 Offsets: c = Y - Yoff; d = U - 128; e = V - 128; signed; Yoff = 16 (modes 0, 2), 0 (mode 1).
REQ-023 Coefficients (Ky, Kr, Kgu, Kgv, Kbu):
- mode 0: 298, 409, 100, 208, 516
- mode 1: 256, 359, 88, 183, 454
- mode 2: 298, 459, 55, 136, 541
REQ-024 Arithmetic:
- R = (Ky*c + Kr*e + 128) >>> 8
- G = (Ky*c - Kgu*d - Kgv*e + 128) >>> 8
- B = (Ky*c + Kbu*d + 128) >>> 8
- all intermediates signed, at least 20 bits, no overflow.
REQ-025 Clamp: results <0 become 0; results >255 become 255.
REQ-026 Mode 3: lane data passes unchanged, byte 3 included; latency identical.
REQ-027 Mode sampling: mode and alpha are sampled on the first beat of each packet and held until that packet's t_last beat is accepted; mid-packet changes take effect at the next packet.
REQ-028 First beat: the first beat after reset, and each beat following an accepted t_last beat.
REQ-029 Sideband routing: dst.t_last = src.t_last; dst.t_user = src.t_user >> 1; dst.t_dest = src.t_user[0] ? CHAIN_ID : 0.
REQ-030 Constant outputs: dst.t_keep = all-ones; dst.t_strb = all-ones; dst.t_id = 0.
REQ-031 Partial input: a src beat with any t_keep bit = 0 is processed as full; a simulation $error is raised.
REQ-032 pkt_count: increments on each dst handshake with t_last = 1; wraps 0xFFFFFFFF to 0.

Reset
REQ-033 On aresetn low, asynchronously:
- dst.t_valid = 0, dst.t_last = 0
- src.t_ready = 0
- all stage-valid flags = 0, skid buffer empty
- pkt_count = 0, latched mode = 0
REQ-034 Reset mid-operation: all in-flight beats are discarded; no beat from before reset appears after it.
REQ-035 Release: src.t_ready = 1 on the first aclk edge after aresetn deasserts.

Verification
REQ-036 Mode 0 colours, dst ready, lane Y/U/V in, RGB out:
- 235/128/128 -> 255/255/255
- 16/128/128 -> 0/0/0
- 81/90/240 -> 255/0/0
- result on dst at N+4
REQ-037 Mode 1, Y/U/V = 0/128/128 -> 0/0/0; mode 3, data 0x11223344 -> 0x11223344.
REQ-038 Backpressure: 100-beat packet; random src.t_valid and dst.t_ready at 50%; output sequence matches the reference model; t_last only on beat 100; pkt_count = 1.
REQ-039 Mode change: mode switched 0 -> 2 on beat 3 of a 5-beat packet -> all 5 beats use mode 0; the next packet uses mode 2.
REQ-040 Routing: t_user = 2'b11, CHAIN_ID = 5 -> dst.t_user = 1, dst.t_dest = 5; t_user = 2'b10 -> dst.t_user = 1, dst.t_dest = 0.
REQ-041 Reset mid-stream: aresetn pulsed with 3 beats in flight -> dst.t_valid = 0 immediately; pkt_count = 0; no stale beat appears; the first beat after reset has latency 4.
